// File: rtl/beta_pkg.sv
// Shared definitions for the Beta PC unit.
// Holds the reset and trap vector addresses, the next-PC select encoding,
// and the branch-offset helper that sign-extends and word-scales a literal.
package beta_pkg;

  localparam logic [31:0] RESET_ADDR = 32'h8000_0000;
  localparam logic [31:0] ILLOP_ADDR = 32'h8000_0004;
  localparam logic [31:0] XADR_ADDR  = 32'h8000_0008;

  typedef enum logic [2:0] {
    PCSEL_INC   = 3'd0,
    PCSEL_BR    = 3'd1,
    PCSEL_JMP   = 3'd2,
    PCSEL_ILLOP = 3'd3,
    PCSEL_XADR  = 3'd4
  } pcsel_e;

  // Byte offset of a branch literal, truncated to the 31 address bits
  // that take part in PC arithmetic (bit 31 is the supervisor flag).
  function automatic logic [30:0] br_offset(input logic [15:0] lit);
    return {{13{lit[15]}}, lit, 2'b00};
  endfunction

endpackage

// File: rtl/beta_next_pc.sv
// Combinational next-PC candidate computation for the Beta PC unit.
// Ports:
//   pc        current PC (bit 31 = supervisor)
//   pcsel     next-PC select from control (5..7 behave as ILLOP)
//   lit       branch literal of the current instruction
//   jt        jump target (Reg[Ra])
//   pc_plus4  PC+4 with the supervisor bit carried through
//   pc_next   selected next PC, before reset/stall/interrupt priority
module beta_next_pc
  import beta_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [2:0]  pcsel,
  input  logic [15:0] lit,
  input  logic [31:0] jt,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_next
);

  logic [30:0] inc_low;
  logic [31:0] br_target;
  logic [31:0] jmp_target;

  // Address arithmetic wraps inside bits 30:0 so it can never change mode.
  assign inc_low   = pc[30:0] + 31'd4;
  assign pc_plus4  = {pc[31], inc_low};
  assign br_target = {pc[31], inc_low + br_offset(lit)};

  // A jump may drop the supervisor bit but can never set it.
  assign jmp_target = {pc[31] & jt[31], jt[30:2], 2'b00};

  always_comb begin
    pc_next = ILLOP_ADDR;
    case (pcsel)
      PCSEL_INC:   pc_next = pc_plus4;
      PCSEL_BR:    pc_next = br_target;
      PCSEL_JMP:   pc_next = jmp_target;
      PCSEL_ILLOP: pc_next = ILLOP_ADDR;
      PCSEL_XADR:  pc_next = XADR_ADDR;
      default:     pc_next = ILLOP_ADDR;
    endcase
  end

endmodule

// File: rtl/beta_pc_unit.sv
// Program counter and next-address unit for the Beta processor.
// Holds the PC (bit 31 = supervisor), latches external interrupts, and
// counts retired instructions.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   stall        hold PC and counter this cycle
//   pcsel        next-PC select (see beta_pkg::pcsel_e)
//   lit, jt      branch literal and jump target
//   irq          level-sensitive external interrupt request
//   ia           current PC to instruction memory
//   pc_plus4     PC+4 of the current instruction
//   take_irq     interrupt taken this cycle
//   instr_count  retired-instruction counter
module beta_pc_unit
  import beta_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  pcsel,
  input  logic [15:0] lit,
  input  logic [31:0] jt,
  input  logic        irq,
  output logic [31:0] ia,
  output logic [31:0] pc_plus4,
  output logic        take_irq,
  output logic [31:0] instr_count
);

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        irq_pending;

  beta_next_pc u_next_pc (
    .pc       (pc),
    .pcsel    (pcsel),
    .lit      (lit),
    .jt       (jt),
    .pc_plus4 (pc_plus4),
    .pc_next  (pc_next)
  );

  // Interrupts are deferred while in supervisor mode and while stalled.
  assign take_irq = irq_pending & ~pc[31] & ~stall & ~reset;
  assign ia       = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_ADDR;
      irq_pending <= 1'b0;
      instr_count <= 32'd0;
    end else begin
      if (!stall) begin
        pc <= take_irq ? XADR_ADDR : pc_next;
      end
      // Taking the interrupt consumes it; a new request re-arms afterwards.
      if (take_irq) begin
        irq_pending <= 1'b0;
      end else if (irq) begin
        irq_pending <= 1'b1;
      end
      if (!stall && !take_irq) begin
        instr_count <= instr_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_beta_pc_unit.sv
module tb_beta_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  pcsel;
  logic [15:0] lit;
  logic [31:0] jt;
  logic        irq;
  logic [31:0] ia;
  logic [31:0] pc_plus4;
  logic        take_irq;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  beta_pc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .pcsel       (pcsel),
    .lit         (lit),
    .jt          (jt),
    .irq         (irq),
    .ia          (ia),
    .pc_plus4    (pc_plus4),
    .take_irq    (take_irq),
    .instr_count (instr_count)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic [2:0]  sel;
    logic [15:0] lit;
    logic [31:0] jt;
    logic        irq;
    logic [31:0] e_ia;
    logic        e_take;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic [2:0] sl, input logic [15:0] l,
                     input logic [31:0] j, input logic q, input logic [31:0] eia,
                     input logic et, input logic [31:0] ec);
    vq.push_back('{r, s, sl, l, j, q, eia, et, ec});
  endtask

  function automatic logic [31:0] plus4(input logic [31:0] p);
    return (p & 32'h8000_0000) | ((p + 32'd4) & 32'h7FFF_FFFF);
  endfunction

  // Reference model state
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_cnt;

  function automatic logic [31:0] ref_target(input logic [31:0] p, input logic [2:0] s,
                                             input logic [15:0] l, input logic [31:0] j);
    int signed off;
    logic [31:0] t;
    off = int'($signed(l)) * 4;
    case (s)
      3'd0: t = plus4(p);
      3'd1: t = (p & 32'h8000_0000) | ((p + 32'd4 + off) & 32'h7FFF_FFFF);
      3'd2: t = ((p[31] && j[31]) ? 32'h8000_0000 : 32'h0) | (j & 32'h7FFF_FFFC);
      3'd4: t = 32'h8000_0008;
      default: t = 32'h8000_0004;
    endcase
    return t;
  endfunction

  initial begin
    logic exp_take;

    reset = 1'b1; stall = 1'b0; pcsel = 3'd0; lit = 16'h0; jt = 32'h0; irq = 1'b0;
    @(negedge clk);
    @(negedge clk);

    //   rst stl sel lit       jt             irq  e_ia           take cnt
    add(0, 0, 0, 16'h0000, 32'h0,          0, 32'h8000_0000, 0, 0);
    add(0, 0, 0, 16'h0000, 32'h0,          0, 32'h8000_0004, 0, 1);
    add(0, 0, 0, 16'h0000, 32'h0,          0, 32'h8000_0008, 0, 2);
    add(0, 0, 2, 16'h0000, 32'h0000_0100,  0, 32'h8000_000C, 0, 3);
    add(0, 0, 1, 16'hFFFE, 32'h0,          0, 32'h0000_0100, 0, 4);
    add(0, 0, 2, 16'h0000, 32'h0000_0100,  0, 32'h0000_00FC, 0, 5);
    add(0, 0, 1, 16'h0003, 32'h0,          0, 32'h0000_0100, 0, 6);
    add(0, 0, 3, 16'h0000, 32'h0,          0, 32'h0000_0110, 0, 7);
    add(0, 0, 1, 16'h000E, 32'h0,          0, 32'h8000_0004, 0, 8);
    add(0, 0, 2, 16'h0000, 32'h0000_2003,  0, 32'h8000_0040, 0, 9);
    add(0, 0, 2, 16'h0000, 32'h8000_0010,  0, 32'h0000_2000, 0, 10);
    add(0, 0, 4, 16'h0000, 32'h0,          0, 32'h0000_0010, 0, 11);
    add(0, 0, 7, 16'h0000, 32'h0,          0, 32'h8000_0008, 0, 12);
    add(0, 0, 0, 16'h0000, 32'h0,          1, 32'h8000_0004, 0, 13);
    add(0, 0, 0, 16'h0000, 32'h0,          0, 32'h8000_0008, 0, 14);
    add(0, 0, 2, 16'h0000, 32'h0000_0300,  0, 32'h8000_000C, 0, 15);
    add(0, 0, 0, 16'h0000, 32'h0,          0, 32'h0000_0300, 1, 16);
    add(0, 0, 2, 16'h0000, 32'h0000_0040,  0, 32'h8000_0008, 0, 16);
    add(0, 1, 1, 16'h0005, 32'h0,          0, 32'h0000_0040, 0, 17);
    add(0, 1, 0, 16'h0000, 32'h0,          0, 32'h0000_0040, 0, 17);
    add(0, 1, 3, 16'h0000, 32'h0,          0, 32'h0000_0040, 0, 17);
    add(0, 1, 1, 16'h0005, 32'h0,          0, 32'h0000_0040, 0, 17);
    add(0, 0, 1, 16'h0005, 32'h0,          0, 32'h0000_0040, 0, 17);
    add(0, 1, 0, 16'h0000, 32'h0,          1, 32'h0000_0058, 0, 18);
    add(0, 1, 0, 16'h0000, 32'h0,          0, 32'h0000_0058, 0, 18);
    add(0, 0, 0, 16'h0000, 32'h0,          0, 32'h0000_0058, 1, 18);
    add(0, 0, 2, 16'h0000, 32'h0000_0200,  0, 32'h8000_0008, 0, 18);
    add(0, 1, 0, 16'h0000, 32'h0,          1, 32'h0000_0200, 0, 19);
    add(1, 1, 0, 16'h0000, 32'h0,          0, 32'h0000_0200, 0, 19);
    add(0, 0, 2, 16'h0000, 32'h7FFF_FFFC,  0, 32'h8000_0000, 0, 0);
    add(0, 0, 0, 16'h0000, 32'h0,          0, 32'h7FFF_FFFC, 0, 1);
    add(0, 0, 0, 16'h0000, 32'h0,          0, 32'h0000_0000, 0, 2);

    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst; stall = vq[i].stl; pcsel = vq[i].sel;
      lit = vq[i].lit; jt = vq[i].jt; irq = vq[i].irq;
      #1;
      chk($sformatf("vec%0d ia", i), ia, vq[i].e_ia);
      chk($sformatf("vec%0d pc_plus4", i), pc_plus4, plus4(vq[i].e_ia));
      chk($sformatf("vec%0d take_irq", i), {31'd0, take_irq}, {31'd0, vq[i].e_take});
      chk($sformatf("vec%0d instr_count", i), instr_count, vq[i].e_cnt);
      @(negedge clk);
    end

    // Randomized run against the reference model; the first cycle resets
    // both DUT and model, so it is not compared.
    m_pc = 32'h0; m_pend = 1'b0; m_cnt = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      reset = (i == 0) || ($urandom_range(0, 99) == 0);
      stall = ($urandom_range(0, 3) == 0);
      irq   = ($urandom_range(0, 7) == 0);
      pcsel = 3'($urandom_range(0, 7));
      lit   = 16'($urandom);
      jt    = ($urandom_range(0, 1) == 0) ? 32'($urandom) : (32'($urandom) & 32'h0000_0FFF);
      #1;
      exp_take = m_pend && !m_pc[31] && !stall && !reset;
      if (i != 0) begin
        chk("rnd ia", ia, m_pc);
        chk("rnd pc_plus4", pc_plus4, plus4(m_pc));
        chk("rnd take_irq", {31'd0, take_irq}, {31'd0, exp_take});
        chk("rnd instr_count", instr_count, m_cnt);
      end
      if (reset) begin
        m_pc = 32'h8000_0000; m_pend = 1'b0; m_cnt = 32'h0;
      end else begin
        if (!stall) m_pc = exp_take ? 32'h8000_0008 : ref_target(m_pc, pcsel, lit, jt);
        if (!stall && !exp_take) m_cnt = m_cnt + 32'd1;
        m_pend = exp_take ? 1'b0 : (m_pend | irq);
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
